nurn_spike_aer_tx: RTL and testbench
====================================

Name: nurn_spike_aer_tx

Overview:
Output-side spike packetizer for a multi-neuron core. It accepts per-neuron fire events from the datapath, together with the neuron's configured AER word, and tags each one with the current time-step. Packets are buffered in a FIFO and handed to the router over a valid/ready handshake. This replaces the single-word SpikePacket/outSpike pair with a queued, time-stamped, back-pressure-aware stream, and adds a per-step duplicate filter and overflow policy.

Parameters:
NUM_NURNS, 4, neurons in the core
NURN_CNT_BIT_WIDTH, 2, width of neuron index, clog2(NUM_NURNS)
AER_BIT_WIDTH, 32, packet width
TS_BIT_WIDTH, 8, time-step tag width, placed in packet MSBs
FIFO_DEPTH, 8, packet buffer entries, power of two
FIFO_CNT_BIT_WIDTH, 4, occupancy width, clog2(FIFO_DEPTH)+1
STAT_BIT_WIDTH, 16, width of the saturating statistics counters

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  time-step start pulse, same signal the controller uses
clear_i  in  1  synchronous flush of FIFO and duplicate bitmap
drop_mode_i  in  1  1 = drop on full; 0 = stall (back-pressure)
spike_vld_i  in  1  neuron fired this cycle
spike_nurn_i  in  NURN_CNT_BIT_WIDTH  index of the firing neuron
spike_aer_i  in  AER_BIT_WIDTH  configured AER word of that neuron
spike_rdy_o  out  1  event accepted when spike_vld_i & spike_rdy_o
pkt_o  out  AER_BIT_WIDTH  head packet
pkt_vld_o  out  1  head packet valid
pkt_rdy_i  in  1  router accepts head packet
ts_o  out  TS_BIT_WIDTH  current time-step tag
fifo_cnt_o  out  FIFO_CNT_BIT_WIDTH  current occupancy
drop_cnt_o  out  STAT_BIT_WIDTH  packets lost to overflow, saturating
dup_cnt_o  out  STAT_BIT_WIDTH  duplicate spikes filtered, saturating

Behaviour:
- Reset (async, rst_n_i low): FIFO empty, pkt_vld_o=0, pkt_o=0, ts_o=0, fifo_cnt_o=0, drop_cnt_o=0, dup_cnt_o=0, bitmap all 0.
- spike_rdy_o is 1 after reset. A reset asserted mid-operation discards all queued packets.
- Packet format: pkt = {ts_tag, spike_aer_i[AER_BIT_WIDTH-TS_BIT_WIDTH-1:0]}.
- Time-step handling:
  - start_i increments ts_o modulo 2^TS_BIT_WIDTH (255 wraps to 0) and clears the sent-bitmap.
  - A spike arriving in the same cycle as start_i belongs to the new step: it is tagged ts_o+1 and passes the cleared bitmap.
- Duplicate filter: one bit per neuron.
  - If spike_vld_i and the bitmap bit for spike_nurn_i is already set, the event is consumed (spike_rdy_o still applies), not written, and dup_cnt_o increments.
  - Otherwise, on write, the bit is set.
  - A dropped (overflow) spike does not set its bit.
- FIFO: first-word-fall-through.
  - A write makes pkt_vld_o=1 on the next cycle (1-cycle latency to output).
  - Pop occurs on pkt_vld_o & pkt_rdy_i. pkt_o and pkt_vld_o are held stable while pkt_vld_o=1 and pkt_rdy_i=0.
  - Simultaneous push and pop when not full and not empty: occupancy is unchanged.
  - Push into an empty FIFO with pkt_rdy_i=1: the packet is not bypassed; it appears the next cycle.
- Full behaviour. "Full" is the registered occupancy == FIFO_DEPTH; a same-cycle pop never frees space. There is no combinational path from pkt_rdy_i to spike_rdy_o.
  - Stall mode (drop_mode_i=0): spike_rdy_o = !full, so the event is held upstream.
  - Drop mode (drop_mode_i=1): spike_rdy_o = 1. A non-duplicate event arriving while full is discarded and drop_cnt_o increments.
- drop_cnt_o and dup_cnt_o saturate at all-ones and are cleared only by reset.
- clear_i: on the next edge the FIFO is empty, pkt_vld_o=0 and the bitmap is zero. ts_o and the statistics counters are kept. An input event in the same cycle as clear_i is discarded and not counted. clear_i has priority over start_i for the bitmap, but ts_o still increments.
- fifo_cnt_o is registered and equals the true occupancy.

Test Plan:
- Reset, then start_i, then neurons 0..3 spike with aer=32'h0000_1000+n, rdy held 1 -> pkt_o = 32'h0100_1000..32'h0100_1003 in order, pkt_vld_o one cycle after each write, ts_o=1.
- Neuron 2 spikes twice in step 1, and once after the next start_i -> two packets (ts 1 and ts 2); dup_cnt_o=1.
- Stall mode, pkt_rdy_i=0, 10 spikes offered from distinct steps -> 8 accepted, spike_rdy_o=0 at fifo_cnt_o=8. After pkt_rdy_i=1, the remaining 2 are accepted; drop_cnt_o=0.
- Drop mode, same stimulus -> fifo_cnt_o=8, drop_cnt_o=2, spike_rdy_o stays 1. Head packet is unchanged while stalled.
- 256 start_i pulses -> ts_o wraps 255->0; a packet in the wrapped step carries tag 8'h00.
- FIFO holding 5 packets, clear_i with a same-cycle spike -> next cycle fifo_cnt_o=0, pkt_vld_o=0, counters unchanged. A mid-stream rst_n_i pulse then zeroes every output asynchronously.

Source files
------------

// File: rtl/nurn_spike_aer_tx.sv
// nurn_spike_aer_tx
//   Output-side spike packetizer. Fire events from the neuron datapath are
//   tagged with the current time-step, filtered so that each neuron emits at
//   most one packet per step, queued in a first-word-fall-through FIFO and
//   offered to the router over a valid/ready handshake.
//
// Ports
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   start_i           time-step start pulse (advances ts_o, clears bitmap)
//   clear_i           synchronous flush of FIFO and duplicate bitmap
//   drop_mode_i       1 = drop on full, 0 = back-pressure on full
//   spike_vld_i/_rdy_o, spike_nurn_i, spike_aer_i   input event handshake
//   pkt_o, pkt_vld_o, pkt_rdy_i                     packet stream to router
//   ts_o              current time-step tag
//   fifo_cnt_o        registered FIFO occupancy
//   drop_cnt_o        saturating count of packets lost to overflow
//   dup_cnt_o         saturating count of filtered duplicate spikes
module nurn_spike_aer_tx #(
  parameter int unsigned NUM_NURNS          = 4,
  parameter int unsigned NURN_CNT_BIT_WIDTH = 2,
  parameter int unsigned AER_BIT_WIDTH      = 32,
  parameter int unsigned TS_BIT_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned FIFO_CNT_BIT_WIDTH = 4,
  parameter int unsigned STAT_BIT_WIDTH     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic                          drop_mode_i,
  input  logic                          spike_vld_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0] spike_nurn_i,
  input  logic [AER_BIT_WIDTH-1:0]      spike_aer_i,
  output logic                          spike_rdy_o,
  output logic [AER_BIT_WIDTH-1:0]      pkt_o,
  output logic                          pkt_vld_o,
  input  logic                          pkt_rdy_i,
  output logic [TS_BIT_WIDTH-1:0]       ts_o,
  output logic [FIFO_CNT_BIT_WIDTH-1:0] fifo_cnt_o,
  output logic [STAT_BIT_WIDTH-1:0]     drop_cnt_o,
  output logic [STAT_BIT_WIDTH-1:0]     dup_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PAY_W = AER_BIT_WIDTH - TS_BIT_WIDTH;

  logic [TS_BIT_WIDTH-1:0]       ts_q, ts_d;
  logic [NUM_NURNS-1:0]          bitmap_q, bitmap_d;
  logic [NUM_NURNS-1:0]          bitmap_step;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [STAT_BIT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;
  logic [STAT_BIT_WIDTH-1:0]     dup_cnt_q, dup_cnt_d;
  logic [AER_BIT_WIDTH-1:0]      mem_q [FIFO_DEPTH];

  logic                          full;
  logic                          rdy;
  logic                          accept;
  logic                          dup;
  logic                          push;
  logic                          drop;
  logic                          pop;
  logic [AER_BIT_WIDTH-1:0]      pkt_in;

  // The time-step field of the AER word is replaced by the tag.
  logic unused_aer_hi;
  assign unused_aer_hi = ^spike_aer_i[AER_BIT_WIDTH-1:PAY_W];

  always_comb begin
    // Full is taken from registered occupancy only, so a same-cycle pop never
    // frees a slot and pkt_rdy_i has no path to spike_rdy_o.
    full        = (cnt_q == FIFO_CNT_BIT_WIDTH'(FIFO_DEPTH));
    rdy         = drop_mode_i | ~full;

    ts_d        = start_i ? ts_q + TS_BIT_WIDTH'(1) : ts_q;
    // A spike in the start_i cycle belongs to the new step.
    bitmap_step = start_i ? '0 : bitmap_q;

    accept      = spike_vld_i & rdy & ~clear_i;
    dup         = accept & bitmap_step[spike_nurn_i];
    push        = accept & ~dup & ~full;
    drop        = accept & ~dup & full;
    pop         = (cnt_q != '0) & pkt_rdy_i & ~clear_i;

    pkt_in      = {ts_d, spike_aer_i[PAY_W-1:0]};

    bitmap_d = bitmap_step;
    if (push) begin
      bitmap_d[spike_nurn_i] = 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + FIFO_CNT_BIT_WIDTH'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - FIFO_CNT_BIT_WIDTH'(1);
    end

    if (clear_i) begin
      bitmap_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + STAT_BIT_WIDTH'(1);
    end

    dup_cnt_d = dup_cnt_q;
    if (dup && (dup_cnt_q != '1)) begin
      dup_cnt_d = dup_cnt_q + STAT_BIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_q       <= '0;
      bitmap_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      dup_cnt_q  <= '0;
    end else begin
      ts_q       <= ts_d;
      bitmap_q   <= bitmap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only visible once counted in cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pkt_in;
    end
  end

  assign spike_rdy_o = rdy;
  assign pkt_vld_o   = (cnt_q != '0);
  assign pkt_o       = pkt_vld_o ? mem_q[rd_ptr_q] : '0;
  assign ts_o        = ts_q;
  assign fifo_cnt_o  = cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign dup_cnt_o   = dup_cnt_q;

endmodule

// File: tb/tb_nurn_spike_aer_tx.sv
module tb_nurn_spike_aer_tx;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        drop_mode_i = 1'b0;
  logic        spike_vld_i = 1'b0;
  logic [1:0]  spike_nurn_i = '0;
  logic [31:0] spike_aer_i = '0;
  logic        spike_rdy_o;
  logic [31:0] pkt_o;
  logic        pkt_vld_o;
  logic        pkt_rdy_i = 1'b0;
  logic [7:0]  ts_o;
  logic [3:0]  fifo_cnt_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] dup_cnt_o;

  nurn_spike_aer_tx #(
    .NUM_NURNS(4), .NURN_CNT_BIT_WIDTH(2), .AER_BIT_WIDTH(32), .TS_BIT_WIDTH(8),
    .FIFO_DEPTH(8), .FIFO_CNT_BIT_WIDTH(4), .STAT_BIT_WIDTH(16)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clear_i(clear_i),
    .drop_mode_i(drop_mode_i), .spike_vld_i(spike_vld_i), .spike_nurn_i(spike_nurn_i),
    .spike_aer_i(spike_aer_i), .spike_rdy_o(spike_rdy_o), .pkt_o(pkt_o),
    .pkt_vld_o(pkt_vld_o), .pkt_rdy_i(pkt_rdy_i), .ts_o(ts_o), .fifo_cnt_o(fifo_cnt_o),
    .drop_cnt_o(drop_cnt_o), .dup_cnt_o(dup_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time-step counter, per-neuron sent flags, packet queue.
  int          m_ts;
  bit [3:0]    m_bm;
  logic [31:0] m_q[$];
  int          m_drop;
  int          m_dup;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    return drop_mode_i || (m_q.size() < 8);
  endfunction

  function automatic void model_reset();
    m_ts = 0; m_bm = '0; m_q.delete(); m_drop = 0; m_dup = 0; m_acc = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit cl, input bit vld,
                                     input int nurn, input logic [31:0] aer, input bit rdy);
    bit full;
    bit do_pop;
    logic [31:0] p;
    full   = (m_q.size() >= 8);
    do_pop = (m_q.size() != 0) && rdy;
    m_acc  = vld && (drop_mode_i || !full);
    if (st) begin
      m_ts = (m_ts + 1) % 256;
      m_bm = '0;
    end
    if (cl) begin
      m_q.delete();
      m_bm = '0;
      return;
    end
    if (do_pop) void'(m_q.pop_front());
    if (m_acc) begin
      if (m_bm[nurn]) begin
        if (m_dup < 65535) m_dup++;
      end else if (full) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        p = aer;
        p[31:24] = 8'(m_ts);
        m_q.push_back(p);
        m_bm[nurn] = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("pkt_vld",  32'(pkt_vld_o),  32'(m_q.size() != 0));
    chk("pkt",      pkt_o,           (m_q.size() != 0) ? m_q[0] : 32'h0);
    chk("ts",       32'(ts_o),       32'(m_ts));
    chk("fifo_cnt", 32'(fifo_cnt_o), 32'(m_q.size()));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    chk("dup_cnt",  32'(dup_cnt_o),  32'(m_dup));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks around the edge.
  task automatic step(input bit st, input bit cl, input bit vld, input int nurn,
                      input logic [31:0] aer, input bit rdy);
    logic [1:0] n2;
    n2 = nurn[1:0];
    start_i = st; clear_i = cl; spike_vld_i = vld;
    spike_nurn_i = n2; spike_aer_i = aer; pkt_rdy_i = rdy;
    #1;
    chk("spike_rdy", 32'(spike_rdy_o), 32'(m_rdy()));
    @(posedge clk_i);
    model_edge(st, cl, vld, nurn, aer, rdy);
    #1;
    check_outputs();
    start_i = 1'b0; clear_i = 1'b0; spike_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    start_i = 1'b0; clear_i = 1'b0; spike_vld_i = 1'b0; pkt_rdy_i = 1'b0;
    drop_mode_i = 1'b0;
    #2;
    model_reset();
    check_outputs();
    chk("rst_spike_rdy", 32'(spike_rdy_o), 32'h1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    // Ordered packets tagged with step 1.
    step(1, 0, 0, 0, 32'h0, 1);
    for (int n = 0; n < 4; n++) begin
      step(0, 0, 1, n, 32'h0000_1000 + n, 1);
      chk("order_pkt", pkt_o, 32'h0100_1000 + n);
    end
    step(0, 0, 0, 0, 32'h0, 1);
    chk("order_ts", 32'(ts_o), 32'h1);

    // Duplicate filtering within a step, re-arm on next step.
    do_reset();
    step(1, 0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 2, 32'h0000_2222, 0);
    step(0, 0, 1, 2, 32'h0000_3333, 0);
    step(1, 0, 1, 2, 32'h0000_4444, 0);
    chk("dup_one", 32'(dup_cnt_o), 32'h1);
    chk("dup_fifo2", 32'(fifo_cnt_o), 32'h2);
    chk("dup_head", pkt_o, 32'h0100_2222);
    step(0, 0, 0, 0, 32'h0, 1);
    chk("dup_second", pkt_o, 32'h0200_4444);

    // Stall mode back-pressure.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 32'h00AA_0000 + i, 0);
    #1;
    chk("stall_full_cnt", 32'(fifo_cnt_o), 32'h8);
    chk("stall_full_rdy", 32'(spike_rdy_o), 32'h0);
    for (int i = 8; i < 10; i++) begin
      int tries = 0;
      do begin
        step(1, 0, 1, 0, 32'h00AA_0000 + i, 1);
        tries++;
      end while (!m_acc && tries < 10);
      chk("stall_accept_in_time", 32'(m_acc), 32'h1);
    end
    chk("stall_no_drop", 32'(drop_cnt_o), 32'h0);

    // Drop mode overflow.
    do_reset();
    drop_mode_i = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 32'hAB00_0100 + i, 0);
    #1;
    chk("drop_cnt8", 32'(fifo_cnt_o), 32'h8);
    chk("drop_two", 32'(drop_cnt_o), 32'h2);
    chk("drop_rdy", 32'(spike_rdy_o), 32'h1);
    chk("drop_head", pkt_o, 32'h0100_0100);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("drop_head_held", pkt_o, 32'h0100_0100);

    // Time-step wrap.
    do_reset();
    for (int i = 0; i < 255; i++) step(1, 0, 0, 0, 32'h0, 1);
    chk("ts_255", 32'(ts_o), 32'hFF);
    step(1, 0, 1, 1, 32'h77C0_FFEE, 1);
    chk("ts_wrap", 32'(ts_o), 32'h0);
    chk("wrap_pkt", pkt_o, 32'h00C0_FFEE);

    // Flush with a same-cycle spike, then asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 32'h0000_5000 + i, 0);
    step(0, 0, 1, 3, 32'h0000_5555, 0);
    chk("pre_clear_dup", 32'(dup_cnt_o), 32'h1);
    step(0, 1, 1, 3, 32'h0000_6666, 0);
    chk("clear_cnt", 32'(fifo_cnt_o), 32'h0);
    chk("clear_vld", 32'(pkt_vld_o), 32'h0);
    chk("clear_dup_kept", 32'(dup_cnt_o), 32'h1);
    chk("clear_ts_kept", 32'(ts_o), 32'h5);
    step(0, 0, 1, 3, 32'h0000_7777, 0);
    chk("post_clear_rearmed", pkt_o, 32'h0500_7777);
    step(0, 0, 1, 0, 32'h0000_8888, 0);
    do_reset();
    chk("rst_ts", 32'(ts_o), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 49) == 0) drop_mode_i = ~drop_mode_i;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
